// File: rtl/dsm_pkg.sv
// Shared constants and helpers for the delta-sigma DAC modulators.
package dsm_pkg;

   localparam logic DSM_MODE_FIRST  = 1'b0;
   localparam logic DSM_MODE_SECOND = 1'b1;

   // Integrator headroom above the sample width; saturation sits two bits
   // below the top so that one feedback step never overflows the register.
   localparam int DSM_GUARD = 4;

   // Clamp a wide signed value to +/-(2^(res+2)-1).
   function automatic logic signed [63:0] dsm_sat(input logic signed [63:0] v,
                                                  input int res);
      logic signed [63:0] lim;
      lim = (64'sd1 <<< (res + DSM_GUARD - 2)) - 64'sd1;
      if (v > lim)
         return lim;
      else if (v < -lim)
         return -lim;
      return v;
   endfunction

endpackage

// File: rtl/dsm_channel.sv
// One modulator channel: first-order accumulator or second-order loop,
// cleared to zero state on a mode-change tick.
module dsm_channel
   import dsm_pkg::*;
#(
   parameter int DAC_RES = 24
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               tick_i,
   input  logic               mode_i,
   input  logic               clear_i,
   input  logic [DAC_RES-1:0] x_i,
   output logic               dac_o
);

   localparam int W = DAC_RES + DSM_GUARD;

   // acc holds the low DAC_RES bits; its carry bit lives in dac_q, which
   // together make up the DAC_RES+1 bit first-order accumulator.
   logic [DAC_RES-1:0]   acc;
   logic signed [W-1:0]  i1, i2;
   logic                 dac_q;

   logic [DAC_RES:0]     acc_nxt;
   logic signed [63:0]   fb, i1_wide, i2_wide, i1_sat, i2_sat;

   // Next-state arithmetic for both loop orders, evaluated in wide signed math.
   always_comb begin
      acc_nxt = {1'b0, acc} + {1'b0, x_i};
      fb      = dac_q ? (64'sd1 <<< DAC_RES) : 64'sd0;
      i1_wide = 64'(i1) + 64'($signed({1'b0, x_i})) - fb;
      i1_sat  = dsm_sat(i1_wide, DAC_RES);
      i2_wide = 64'(i2) + i1_sat - fb;
      i2_sat  = dsm_sat(i2_wide, DAC_RES);
   end

   // Modulator state advances only on a tick; a mode change restarts from zero.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         acc   <= '0;
         i1    <= '0;
         i2    <= '0;
         dac_q <= 1'b0;
      end else if (tick_i) begin
         if (clear_i) begin
            acc   <= '0;
            i1    <= '0;
            i2    <= '0;
            dac_q <= 1'b0;
         end else if (mode_i == DSM_MODE_SECOND) begin
            i1    <= i1_sat[W-1:0];
            i2    <= i2_sat[W-1:0];
            dac_q <= (i2_sat > 64'sd0);
         end else begin
            acc   <= acc_nxt[DAC_RES-1:0];
            dac_q <= acc_nxt[DAC_RES];
         end
      end
   end

   assign dac_o = dac_q;

endmodule

// File: rtl/dsm_dac_multi.sv
// Multi-channel delta-sigma DAC: sample double buffer, handshake, underrun
// detection and mode tracking shared by N_CH independent modulators.
module dsm_dac_multi
   import dsm_pkg::*;
#(
   parameter int DAC_RES = 24,
   parameter int N_CH    = 2
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    dac_clk_i,
   input  logic                    mode_i,
   input  logic [N_CH*DAC_RES-1:0] din_i,
   input  logic                    din_valid_i,
   output logic                    din_ready_o,
   output logic [N_CH-1:0]         dac_o,
   output logic                    underrun_o
);

   logic [N_CH-1:0][DAC_RES-1:0] staged, active, x;
   logic                         staged_full, primed, mode_q;
   logic                         accept, clear;

   assign din_ready_o = !staged_full;
   assign accept      = din_valid_i && din_ready_o;
   // A staged sample is consumed by the tick; otherwise the last one repeats.
   assign x           = staged_full ? staged : active;
   assign clear       = dac_clk_i && (mode_i != mode_q);

   // Staging register: filled on accept, emptied by the consuming tick.
   // Accept only happens while empty, so it takes priority over the drain.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         staged      <= '0;
         staged_full <= 1'b0;
         primed      <= 1'b0;
      end else if (accept) begin
         staged      <= din_i;
         staged_full <= 1'b1;
         primed      <= 1'b1;
      end else if (dac_clk_i) begin
         staged_full <= 1'b0;
      end
   end

   // Active sample, sampled mode and the one-cycle underrun pulse.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         active     <= '0;
         mode_q     <= DSM_MODE_FIRST;
         underrun_o <= 1'b0;
      end else begin
         underrun_o <= dac_clk_i && !staged_full && primed;
         if (dac_clk_i) begin
            active <= x;
            mode_q <= mode_i;
         end
      end
   end

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      dsm_channel #(.DAC_RES(DAC_RES)) u_ch (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .tick_i  (dac_clk_i),
         .mode_i  (mode_i),
         .clear_i (clear),
         .x_i     (x[k]),
         .dac_o   (dac_o[k])
      );
   end

endmodule

// File: tb/tb_dsm_dac_multi.sv
// Self-checking bench: behavioural model compared every cycle, plus directed
// literal expectations for the scenarios of interest.
module tb_dsm_dac_multi;

   localparam int RES = 8;
   localparam int NCH = 2;
   localparam int LIM = (1 << (RES + 2)) - 1;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                dac_clk = 1'b0;
   logic                mode = 1'b0;
   logic [NCH*RES-1:0]  din = '0;
   logic                din_valid = 1'b0;
   logic                din_ready;
   logic [NCH-1:0]      dac;
   logic                underrun;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   dsm_dac_multi #(.DAC_RES(RES), .N_CH(NCH)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .dac_clk_i   (dac_clk),
      .mode_i      (mode),
      .din_i       (din),
      .din_valid_i (din_valid),
      .din_ready_o (din_ready),
      .dac_o       (dac),
      .underrun_o  (underrun)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   int m_acc[NCH], m_i1[NCH], m_i2[NCH], m_staged[NCH], m_active[NCH];
   bit m_dac[NCH];
   bit m_sfull, m_primed, m_modeq, m_under;

   function automatic int clampi(input int v);
      if (v > LIM) return LIM;
      if (v < -LIM) return -LIM;
      return v;
   endfunction

   always @(posedge clk) begin
      int  xv[NCH];
      bit  take;
      if (rst) begin
         for (int c = 0; c < NCH; c++) begin
            m_acc[c] = 0; m_i1[c] = 0; m_i2[c] = 0;
            m_staged[c] = 0; m_active[c] = 0; m_dac[c] = 0;
         end
         m_sfull = 0; m_primed = 0; m_modeq = 0; m_under = 0;
      end else begin
         take = din_valid && !m_sfull;
         if (dac_clk) begin
            for (int c = 0; c < NCH; c++) begin
               xv[c] = m_sfull ? m_staged[c] : m_active[c];
               if (mode != m_modeq) begin
                  m_acc[c] = 0; m_i1[c] = 0; m_i2[c] = 0; m_dac[c] = 0;
               end else if (mode == 1'b0) begin
                  m_acc[c] = m_acc[c] + xv[c];
                  m_dac[c] = (m_acc[c] >= (1 << RES));
                  m_acc[c] = m_acc[c] % (1 << RES);
               end else begin
                  int fbv;
                  fbv = m_dac[c] ? (1 << RES) : 0;
                  m_i1[c] = clampi(m_i1[c] + xv[c] - fbv);
                  m_i2[c] = clampi(m_i2[c] + m_i1[c] - fbv);
                  m_dac[c] = (m_i2[c] > 0);
               end
               m_active[c] = xv[c];
            end
            m_under = !m_sfull && m_primed;
            m_modeq = mode;
            m_sfull = 0;
         end else begin
            m_under = 0;
         end
         if (take) begin
            for (int c = 0; c < NCH; c++) m_staged[c] = int'(din[c*RES +: RES]);
            m_sfull = 1; m_primed = 1;
         end
      end
   end

   // Per-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      if (cmp_en) begin
         logic [NCH-1:0] exp_dac;
         for (int c = 0; c < NCH; c++) exp_dac[c] = m_dac[c];
         checks++;
         if (dac !== exp_dac || underrun !== m_under || din_ready !== !m_sfull) begin
            errors++;
            $display("FAIL model t=%0t: dac=%b/%b underrun=%b/%b ready=%b/%b (actual/required)",
                     $time, dac, exp_dac, underrun, m_under, din_ready, !m_sfull);
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0d required %0d", name, act, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1; dac_clk = 0; din_valid = 0;
      @(negedge clk);
      rst = 0;
   endtask

   task automatic load(input logic [NCH*RES-1:0] v);
      @(negedge clk);
      din = v; din_valid = 1;
      @(negedge clk);
      din_valid = 0;
   endtask

   task automatic tick_once(output logic [NCH-1:0] d, output logic u);
      @(negedge clk);
      dac_clk = 1;
      @(negedge clk);
      dac_clk = 0;
      d = dac; u = underrun;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      logic [NCH-1:0] d;
      logic           u;
      int             ones0, ones1, nund;
      logic [NCH*RES-1:0] samp[3];

      do_reset();
      cmp_en = 1;

      // 1: idle ticks after reset
      chk("reset_dac", int'(dac), 0);
      chk("reset_underrun", int'(underrun), 0);
      chk("reset_ready", int'(din_ready), 1);
      nund = 0; ones0 = 0;
      for (int i = 0; i < 10; i++) begin
         tick_once(d, u);
         nund += int'(u); ones0 += int'(d != 0);
      end
      chk("idle_underruns", nund, 0);
      chk("idle_dac_ones", ones0, 0);

      // 2: first order density
      do_reset();
      mode = 0;
      load({8'hC0, 8'h40});
      ones0 = 0; ones1 = 0;
      for (int i = 0; i < 256; i++) begin
         tick_once(d, u);
         if (i == 0) chk("fo_ch1_tick1", int'(d[1]), 0);
         if (i == 1) chk("fo_ch1_tick2", int'(d[1]), 1);
         ones0 += int'(d[0]); ones1 += int'(d[1]);
      end
      chk("fo_ch0_ones", ones0, 64);
      chk("fo_ch1_ones", ones1, 192);

      // 3: second order, extremes
      do_reset();
      mode = 1;
      load({8'hFF, 8'h00});
      tick_once(d, u);                       // mode-change tick: clears
      chk("so_clear_tick", int'(d), 0);
      ones0 = 0; ones1 = 0;
      for (int i = 0; i < 1024; i++) begin
         tick_once(d, u);
         ones0 += int'(d[0]); ones1 += int'(d[1]);
      end
      chk("so_ch0_ones", ones0, 0);
      chk("so_ch1_near_1020", int'(ones1 >= 1018 && ones1 <= 1022), 1);

      // 4: handshake with continuous valid, tick every 4 cycles
      do_reset();
      mode = 0;
      samp[0] = {8'h10, 8'h20}; samp[1] = {8'h30, 8'h40}; samp[2] = {8'h50, 8'hA0};
      begin
         int idx;
         bit acc;
         idx = 0;
         @(negedge clk);
         din = samp[0]; din_valid = 1;
         for (int cyc = 0; cyc < 16; cyc++) begin
            dac_clk = (cyc % 4 == 3);
            acc = din_valid && din_ready;
            @(negedge clk);
            if (acc) begin
               chk("hs_ready_drop", int'(din_ready), 0);
               idx++;
               if (idx == 3) din_valid = 0; else din = samp[idx];
            end
         end
         dac_clk = 0;
         chk("hs_all_accepted", idx, 3);
      end
      nund = 0;
      for (int i = 0; i < 4; i++) begin
         tick_once(d, u);
         nund += int'(u);
      end
      chk("hs_underrun_pulses", nund, 4);

      // 5: accept and tick together with staging empty
      do_reset();
      mode = 0;
      load({8'h80, 8'h80});
      tick_once(d, u);                       // acc = 0x80
      chk("same_pre", int'(d), 0);
      @(negedge clk);
      din = {8'h40, 8'h40}; din_valid = 1; dac_clk = 1;
      @(negedge clk);
      din_valid = 0; dac_clk = 0;
      chk("same_uses_old", int'(dac), 3);    // 0x80+0x80 carries
      chk("same_staged", int'(din_ready), 0);
      tick_once(d, u);
      chk("same_next_new", int'(d), 0);      // 0x00+0x40

      // 6: mode switch mid-stream, then reset mid-stream
      do_reset();
      mode = 0;
      load({8'hC0, 8'hC0});
      tick_once(d, u);
      tick_once(d, u);
      chk("ms_before", int'(d), 3);
      mode = 1;
      tick_once(d, u);
      chk("ms_clear", int'(d), 0);
      for (int i = 0; i < 5; i++) tick_once(d, u);
      @(negedge clk);
      din = {8'h11, 8'h22}; din_valid = 1; dac_clk = 1; rst = 1;
      @(negedge clk);
      rst = 0; din_valid = 0; dac_clk = 0;
      chk("rst_dac", int'(dac), 0);
      chk("rst_underrun", int'(underrun), 0);
      chk("rst_ready", int'(din_ready), 1);
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dsm_dac_multi.md
# dsm_dac_multi

Multi-channel, parametrised delta-sigma DAC modulator with a run-time selectable first- or second-order noise-shaping loop. It takes packed unsigned samples through a valid/ready handshake and double-buffers them. At each modulator strobe it produces one bit per channel. It sits between the sample source (DMA/FIFO or synthesis core) and the output pins, under the same system clock plus modulator-rate strobe scheme as our single-channel first-order DAC.

## Interface
- `DAC_RES`, 24: sample width per channel, unsigned.
- `N_CH`, 2: channel count, ≥1.
- `clk_i` input 1: system clock; all logic on its rising edge.
- `rst_i` input 1: synchronous, active-high reset.
- `dac_clk_i` input 1: modulator strobe, one `clk_i` cycle wide; each high cycle is one "tick".
- `mode_i` input 1: 0 = first order, 1 = second order; quasi-static.
- `din_i` input `N_CH*DAC_RES`: packed samples, channel k at bits `[k*DAC_RES +: DAC_RES]`.
- `din_valid_i` input 1: `din_i` valid.
- `din_ready_o` output 1: staging register empty.
- `dac_o` output `N_CH`: modulated bitstreams, registered.
- `underrun_o` output 1: one-cycle pulse, tick occurred with no new sample.

## Operation
- Staging: `din_ready_o = !staged_full` (combinational from a register). Accept when `din_valid_i && din_ready_o`: `staged <= din_i`, `staged_full <= 1`.
- On tick: `x = staged_full ? staged : active`. Then `active <= x` and `staged_full <= 0`. Every channel modulator updates with its slice of `x`.
- Accept and tick in the same cycle with staging empty: the tick uses `active`, and the new sample is staged.
- Underrun: a tick with `staged_full == 0` and `primed == 1` sets `underrun_o` to 1 for the next cycle, and `active` is reused. `primed` is set on the first accept after reset. No underrun is reported before that.
- Mode is sampled at each tick into `mode_q`. If the sampled mode differs from `mode_q`, every channel clears its integrators and output bit in that tick and restarts from zero state.
- First order (mode 0), per channel: `acc` is `DAC_RES+1` bits. `acc <= acc[DAC_RES-1:0] + x`, `dac_o = acc[DAC_RES]`. Mean of `dac_o` is x/2^DAC_RES.
- Second order (mode 1), per channel:
  - Signed integrators `i1` and `i2`, each `DAC_RES+4` bits.
  - `fb = dac_o ? 2^DAC_RES : 0`.
  - `i1n = i1 + x - fb`, `i2n = i2 + i1n - fb`.
  - `dac_o <= (i2n > 0)`.
  - Both integrators saturate at ±(2^(DAC_RES+2)−1), never wrap.
- Channels are independent, apart from the shared handshake, strobe and mode.
- Between ticks, all modulator state and `dac_o` hold.

## Timing
- Reset values: `dac_o = 0`, `underrun_o = 0`, `din_ready_o = 1`. Also `staged_full`, `primed`, `active`, `acc`, `i1`, `i2` = 0, and `mode_q = 0`.
- Reset mid-stream discards any staged sample and returns to the reset state on the next edge.
- `rst_i` overrides `dac_clk_i` and handshake.
- Latency: a sample accepted at cycle t, with the next tick at cycle T > t, first affects `dac_o` at cycle T+1.
- `din_ready_o` falls the cycle after an accept and rises the cycle after the consuming tick.
- `underrun_o` is high exactly in cycle T+1 of the underrunning tick.
- `dac_o` changes only in the cycle after a tick.

## Structure
- Shared package `dsm_pkg`:
  - Mode constants `DSM_MODE_FIRST = 1'b0` and `DSM_MODE_SECOND = 1'b1`.
  - Integrator guard-bit constant `DSM_GUARD = 4`.
  - Saturation helper function.
- Sub-module `dsm_channel`: one modulator, both orders plus the clear-on-mode-change logic. It is instantiated `N_CH` times by generate.
- The top level holds the staging and active registers, the handshake, `primed`, `mode_q` and the underrun logic.

## Test plan
1. Reset, then 10 ticks with no input: `dac_o = 0`, `underrun_o` never asserts, `din_ready_o = 1`.
2. Mode 0, `DAC_RES=8`, ch0 = 0x40, ch1 = 0xC0, 256 ticks: ch0 emits exactly 64 ones and ch1 exactly 192. The first one on ch1 appears on the 2nd tick.
3. Mode 1, `DAC_RES=8`, ch0 = 0x00 and ch1 = 0xFF for 1024 ticks: ch0 stays all zeros. ch1's ones count is within ±2 of 1020, and `i1`/`i2` never exceed saturation.
4. Handshake: hold `din_valid_i=1` with samples A, B, C and a tick every 4 cycles. Each sample is consumed by exactly one tick, in order, and `din_ready_o` drops the cycle after each accept. Stopping input then gives one `underrun_o` pulse per tick, with `dac_o` continuing on C.
5. Accept and tick in the same cycle with staging empty: the tick uses the old `active`, and the new sample is used on the following tick.
6. Switch `mode_i` 0→1 mid-stream: at the next tick the integrators clear and `dac_o` is 0 for that tick. Then assert `rst_i` for 1 cycle mid-stream: every output returns to its reset value on the next edge.
